// File: rtl/sparc_exu_alu_pipe_if.sv
// sparc_exu_alu_pipe_if: operation-in / result-out channels of the pipelined EXU ALU.
//   in_*  : upstream valid/ready channel carrying opcode, modifiers and operands.
//   out_* : downstream valid/ready channel carrying result, LSU VA, per-lane
//           condition codes and the VA range flag.
// The master modport belongs to the agent that issues operations and consumes
// results. The slave modport belongs to the ALU.
interface sparc_exu_alu_pipe_if #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned VA_BITS = 48
);
  localparam int unsigned LANES = WIDTH / 32;

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic               in_inv;
  logic               in_cin;
  logic [WIDTH-1:0]   in_rs1;
  logic [WIDTH-1:0]   in_rs2;
  logic [WIDTH-1:0]   in_rs3;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_rd;
  logic [VA_BITS-1:0] out_va;
  logic [LANES-1:0]   out_n;
  logic [LANES-1:0]   out_z;
  logic [LANES-1:0]   out_v;
  logic [LANES-1:0]   out_c;
  logic               out_addr_invalid;

  modport master (
    output in_valid, in_op, in_inv, in_cin, in_rs1, in_rs2, in_rs3, out_ready,
    input  in_ready, out_valid, out_rd, out_va, out_n, out_z, out_v, out_c,
           out_addr_invalid
  );

  modport slave (
    input  in_valid, in_op, in_inv, in_cin, in_rs1, in_rs2, in_rs3, out_ready,
    output in_ready, out_valid, out_rd, out_va, out_n, out_z, out_v, out_c,
           out_addr_invalid
  );
endinterface

// File: rtl/sparc_exu_alu_pipe.sv
// sparc_exu_alu_pipe: two-stage pipelined integer ALU (add/sub/logic/move).
//   rclk    : clock; all state updates on the rising edge.
//   rst     : synchronous active-high reset. It flushes both stages and clears the counter.
//   alu     : slave side of sparc_exu_alu_pipe_if (operation in, result out).
//   cnt_clr : synchronous clear of the completion counter. It wins over an increment.
//   cnt_ops : saturating count of completed output handshakes.
// E1 registers the lane-chained adder sum, the selected result, the lane
// carries and the operand signs. E2 registers the result and the condition codes.
module sparc_exu_alu_pipe #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned VA_BITS  = 48,
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                rclk,
  input  logic                rst,
  sparc_exu_alu_pipe_if.slave alu,
  input  logic                cnt_clr,
  output logic [CNT_BITS-1:0] cnt_ops
);
  localparam int unsigned LANES = WIDTH / 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MOVE = 3'd5,
    OP_PASS = 3'd6,
    OP_CASA = 3'd7
  } op_e;

  // Pipeline control
  logic e1_valid, e2_valid;
  logic e1_adv, e2_adv, accept;

  assign e2_adv       = ~e2_valid | alu.out_ready;
  assign e1_adv       = ~e1_valid | e2_adv;
  assign alu.in_ready = e1_adv & ~rst;
  assign accept       = alu.in_valid & alu.in_ready;

  // E1 combinational datapath
  op_e              op;
  logic [WIDTH-1:0] b_eff, b_log, sum, log_res, res, va_full;
  logic [LANES-1:0] lane_co, sign_a, sign_b;
  logic             carry;
  logic [32:0]      lane_sum;

  assign op = op_e'(alu.in_op);

  always_comb begin
    b_eff = (op == OP_SUB) ? ~alu.in_rs2 : alu.in_rs2;
    unique case (op)
      OP_ADD:  carry = alu.in_cin;
      OP_SUB:  carry = ~alu.in_cin;
      default: carry = 1'b0;
    endcase
    sum      = '0;
    lane_co  = '0;
    sign_a   = '0;
    sign_b   = '0;
    lane_sum = '0;
    // The adder is built from 32-bit slices so the carry out of each lane is
    // directly visible. The chained carry keeps the full-width sum exact.
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_sum          = {1'b0, alu.in_rs1[32*k +: 32]} + {1'b0, b_eff[32*k +: 32]}
                          + {32'd0, carry};
      sum[32*k +: 32]   = lane_sum[31:0];
      carry             = lane_sum[32];
      lane_co[k]        = lane_sum[32];
      sign_a[k]         = alu.in_rs1[32*k+31];
      sign_b[k]         = b_eff[32*k+31];
    end
  end

  always_comb begin
    b_log = alu.in_inv ? ~alu.in_rs2 : alu.in_rs2;
    unique case (op)
      OP_AND:  log_res = alu.in_rs1 & b_log;
      OP_OR:   log_res = alu.in_rs1 | b_log;
      OP_XOR:  log_res = alu.in_rs1 ^ b_log;
      default: log_res = '0;
    endcase
  end

  always_comb begin
    unique case (op)
      OP_AND, OP_OR, OP_XOR: res = log_res;
      OP_MOVE:               res = alu.in_rs2;
      OP_PASS:               res = alu.in_rs3;
      default:               res = sum;
    endcase
    va_full = (op == OP_CASA) ? alu.in_rs1 : sum;
  end

  // E1 registers
  op_e              e1_op;
  logic [WIDTH-1:0] e1_res, e1_va;
  logic [LANES-1:0] e1_co, e1_sa, e1_sb;

  always_ff @(posedge rclk) begin
    if (rst) begin
      e1_valid <= 1'b0;
      e1_op    <= OP_ADD;
      e1_res   <= '0;
      e1_va    <= '0;
      e1_co    <= '0;
      e1_sa    <= '0;
      e1_sb    <= '0;
    end else begin
      if (e1_adv) e1_valid <= accept;
      if (accept) begin
        e1_op  <= op;
        e1_res <= res;
        e1_va  <= va_full;
        e1_co  <= lane_co;
        e1_sa  <= sign_a;
        e1_sb  <= sign_b;
      end
    end
  end

  // Condition codes and range check derived from E1
  logic             e1_arith, e1_mism;
  logic [LANES-1:0] cc_n, cc_z, cc_v, cc_c;

  always_comb begin
    e1_arith = (e1_op == OP_ADD) || (e1_op == OP_SUB) || (e1_op == OP_CASA);
    cc_n = '0;
    cc_z = '0;
    cc_v = '0;
    cc_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      cc_n[k] = e1_res[32*k+31];
      cc_z[k] = ~|e1_res[32*k +: 32];
      cc_c[k] = e1_arith & ((e1_op == OP_SUB) ? ~e1_co[k] : e1_co[k]);
      // Signed overflow: both adder inputs share a sign that the sum does not.
      cc_v[k] = e1_arith & (e1_sa[k] == e1_sb[k]) & (e1_res[32*k+31] != e1_sa[k]);
    end
    // The upper bits must be a sign extension of bit VA_BITS-1. The loop is
    // empty when VA_BITS equals WIDTH.
    e1_mism = 1'b0;
    for (int unsigned i = VA_BITS; i < WIDTH; i++) begin
      if (e1_va[i] != e1_va[VA_BITS-1]) e1_mism = 1'b1;
    end
  end

  // E2 / output registers
  always_ff @(posedge rclk) begin
    if (rst) begin
      e2_valid             <= 1'b0;
      alu.out_rd           <= '0;
      alu.out_va           <= '0;
      alu.out_n            <= '0;
      alu.out_z            <= '0;
      alu.out_v            <= '0;
      alu.out_c            <= '0;
      alu.out_addr_invalid <= 1'b0;
    end else if (e2_adv) begin
      e2_valid <= e1_valid;
      if (e1_valid) begin
        alu.out_rd           <= e1_res;
        alu.out_va           <= e1_va[VA_BITS-1:0];
        alu.out_n            <= cc_n;
        alu.out_z            <= cc_z;
        alu.out_v            <= cc_v;
        alu.out_c            <= cc_c;
        alu.out_addr_invalid <= e1_arith & e1_mism;
      end
    end
  end

  assign alu.out_valid = e2_valid;

  // Completion counter
  always_ff @(posedge rclk) begin
    if (rst || cnt_clr) begin
      cnt_ops <= '0;
    end else if (e2_valid && alu.out_ready && (cnt_ops != '1)) begin
      cnt_ops <= cnt_ops + CNT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_sparc_exu_alu_pipe.sv
// Self-checking bench for sparc_exu_alu_pipe (WIDTH=64, VA_BITS=48, CNT_BITS=4).
// The stimulus pushes reference results into a scoreboard queue on accept.
// A monitor pops the queue and compares on every output handshake. A
// cycle-level model of the completion counter is compared every cycle.
module tb_sparc_exu_alu_pipe;
  localparam int W  = 64;
  localparam int VB = 48;
  localparam int CB = 4;
  localparam int L  = W / 32;

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  rd;
    logic [VB-1:0] va;
    logic [L-1:0]  n, z, v, c;
    logic          ai;
  } exp_t;

  logic          rclk = 1'b0;
  logic          rst;
  logic          cnt_clr;
  logic [CB-1:0] cnt_ops;

  sparc_exu_alu_pipe_if #(.WIDTH(W), .VA_BITS(VB)) bus ();

  sparc_exu_alu_pipe #(.WIDTH(W), .VA_BITS(VB), .CNT_BITS(CB)) dut (
    .rclk    (rclk),
    .rst     (rst),
    .alu     (bus.slave),
    .cnt_clr (cnt_clr),
    .cnt_ops (cnt_ops)
  );

  always #5 rclk = ~rclk;

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  int            ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
  int            accepted = 0;
  logic          cnt_live = 1'b0;
  logic [CB-1:0] mcnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It uses plain arithmetic on whole numbers. Carries come
  // from wide unsigned sums and overflow from signed range tests.
  function automatic exp_t model(input logic [2:0] op, input logic inv, input logic cin,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] r3);
    exp_t               e;
    logic [W-1:0]       bb, va, tops;
    logic               ci, arith;
    logic [65:0]        m, us;
    logic signed [65:0] sa, sbv, ss, mx, mn;
    int                 w;
    arith = (op == 3'd0) || (op == 3'd1) || (op == 3'd7);
    bb    = (op == 3'd1) ? ~b : b;
    ci    = (op == 3'd0) ? cin : ((op == 3'd1) ? ~cin : 1'b0);
    e.op  = op;
    case (op)
      3'd2:    e.rd = a & (inv ? ~b : b);
      3'd3:    e.rd = a | (inv ? ~b : b);
      3'd4:    e.rd = a ^ (inv ? ~b : b);
      3'd5:    e.rd = b;
      3'd6:    e.rd = r3;
      default: e.rd = a + bb + W'(ci);
    endcase
    va   = (op == 3'd7) ? a : (a + bb + W'(ci));
    e.va = va[VB-1:0];
    tops = va >> (VB - 1);
    e.ai = arith && !((tops == '0) || (tops == ({W{1'b1}} >> (VB - 1))));
    for (int k = 0; k < L; k++) begin
      w   = 32 * k + 32;
      m   = (66'd1 << w) - 66'd1;
      us  = (66'(a) & m) + (66'(bb) & m) + 66'(ci);
      sa  = $signed(66'(a) << (66 - w)) >>> (66 - w);
      sbv = $signed(66'(bb) << (66 - w)) >>> (66 - w);
      ss  = sa + sbv + $signed({65'd0, ci});
      mx  = (66'sd1 <<< (w - 1)) - 66'sd1;
      mn  = -(66'sd1 <<< (w - 1));
      e.n[k] = e.rd[w-1];
      e.z[k] = (e.rd[32*k +: 32] == 32'd0);
      e.c[k] = arith ? ((op == 3'd1) ? ~us[w] : us[w]) : 1'b0;
      e.v[k] = arith && ((ss > mx) || (ss < mn));
    end
    return e;
  endfunction

  // out_ready driver
  always @(posedge rclk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard monitor
  always @(negedge rclk) begin
    exp_t e;
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got rd %h expected none", bus.out_rd);
      end else begin
        e = sb.pop_front();
        chk("rd", bus.out_rd, e.rd);
        if (e.op == 3'd0 || e.op == 3'd1 || e.op == 3'd7)
          chk("va", 64'(bus.out_va), 64'(e.va));
        chk("n", 64'(bus.out_n), 64'(e.n));
        chk("z", 64'(bus.out_z), 64'(e.z));
        chk("v", 64'(bus.out_v), 64'(e.v));
        chk("c", 64'(bus.out_c), 64'(e.c));
        chk("addr_invalid", 64'(bus.out_addr_invalid), 64'(e.ai));
      end
    end
  end

  // Completion counter model, stepped once per cycle
  always @(negedge rclk) begin
    if (cnt_live) begin
      chk("cnt_ops", 64'(cnt_ops), 64'(mcnt));
      if (rst || cnt_clr) mcnt <= '0;
      else if (bus.out_valid && bus.out_ready && mcnt != '1) mcnt <= mcnt + 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic inv, input logic cin,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r3);
    int n = 0;
    bus.in_op    = op;
    bus.in_inv   = inv;
    bus.in_cin   = cin;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_rs3   = r3;
    bus.in_valid = 1'b1;
    @(negedge rclk);
    while (!bus.in_ready && n < 200) begin
      @(negedge rclk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
    end else begin
      sb.push_back(model(op, inv, cin, a, b, r3));
      accepted++;
    end
    @(posedge rclk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_rs1   = W'({$urandom, $urandom});
  endtask

  // Issue into an empty pipeline with out_ready high. Returns at the negedge
  // of the cycle in which the result is presented.
  task automatic issue_see(input logic [2:0] op, input logic inv, input logic cin,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, inv, cin, a, b, '0);
    @(negedge rclk);
    chk("latency_t1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge rclk);
    chk("latency_t2_valid", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      cyc(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'h0000_7FFF_FFFF_FFFF + W'($urandom_range(0, 3));
      5:       return 64'hFFFF_8000_0000_0000 - W'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst          = 1'b1;
    cnt_clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_inv   = 1'b0;
    bus.in_cin   = 1'b0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_rs3   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    cyc(1);
    cnt_live = 1'b1;
    @(negedge rclk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_rd", bus.out_rd, 64'd0);
    chk("rst_out_va", 64'(bus.out_va), 64'd0);
    chk("rst_cc", 64'({bus.out_n, bus.out_z, bus.out_v, bus.out_c}), 64'd0);
    chk("rst_addr_invalid", 64'(bus.out_addr_invalid), 64'd0);
    chk("rst_cnt", 64'(cnt_ops), 64'd0);
    @(posedge rclk); #1;
    rst = 1'b0;
    @(negedge rclk);
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
    @(posedge rclk); #1;
    ready_mode = 1;
    bus.out_ready = 1'b1;

    // ADD carry/overflow, also checking latency
    issue_see(3'd0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add_rd", bus.out_rd, 64'h8000_0000_0000_0000);
    chk("add_n", 64'(bus.out_n), 64'd2);
    chk("add_v", 64'(bus.out_v), 64'd2);
    chk("add_c", 64'(bus.out_c), 64'd1);
    chk("add_z", 64'(bus.out_z), 64'd1);
    @(posedge rclk); #1;

    // SUB equal operands
    issue_see(3'd1, 1'b0, 1'b0, 64'h1234, 64'h1234);
    chk("sub_rd", bus.out_rd, 64'd0);
    chk("sub_z", 64'(bus.out_z), 64'd3);
    chk("sub_c", 64'(bus.out_c), 64'd0);
    chk("sub_v", 64'(bus.out_v), 64'd0);
    @(posedge rclk); #1;

    // ANDN
    issue_see(3'd2, 1'b1, 1'b0, 64'hFF00, 64'h0F0F);
    chk("andn_rd", bus.out_rd, 64'hF000);
    chk("andn_cv", 64'({bus.out_c, bus.out_v}), 64'd0);
    @(posedge rclk); #1;

    // CASA VA and range checks
    issue_see(3'd7, 1'b0, 1'b1, 64'hFFFF_8000_0000_0000, 64'h5);
    chk("casa_va", 64'(bus.out_va), 64'h8000_0000_0000);
    chk("casa_ai", 64'(bus.out_addr_invalid), 64'd0);
    @(posedge rclk); #1;
    issue_see(3'd0, 1'b0, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'd1);
    chk("add_ai", 64'(bus.out_addr_invalid), 64'd1);
    @(posedge rclk); #1;
    issue_see(3'd5, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 64'hFFFF_0000_1234_0000);
    chk("move_ai", 64'(bus.out_addr_invalid), 64'd0);
    chk("move_rd", bus.out_rd, 64'hFFFF_0000_1234_0000);
    @(posedge rclk); #1;
    drain();

    // Back-pressure: four back-to-back ops with out_ready low
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    ready_mode = 0;
    bus.out_ready = 1'b0;
    accepted = 0;
    fork
      for (int i = 0; i < 4; i++) issue(3'(i % 5), 1'b0, 1'b0, 64'(i + 1), 64'(10 * i + 3), 64'(i));
    join_none
    cyc(6);
    @(negedge rclk);
    chk("bp_accepted", 64'(accepted), 64'd2);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge rclk); #1;
    ready_mode = 1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 50 && accepted < 4; n++) cyc(1);
    wait fork;
    drain();
    cyc(2);
    @(negedge rclk);
    chk("bp_accepted_all", 64'(accepted), 64'd4);
    chk("bp_cnt", 64'(cnt_ops), 64'd4);
    @(posedge rclk); #1;

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) issue(3'd3, 1'b0, 1'b0, 64'(i), 64'(i << 8), '0);
    drain();
    cyc(2);
    @(negedge rclk);
    chk("cnt_saturated", 64'(cnt_ops), 64'd15);
    @(posedge rclk); #1;

    // Clear coinciding with a completion
    issue(3'd4, 1'b1, 1'b0, 64'hA5A5, 64'h0F0F, '0);
    cnt_clr = 1'b1;
    cyc(2);
    cnt_clr = 1'b0;
    @(negedge rclk);
    chk("cnt_clr_wins", 64'(cnt_ops), 64'd0);
    chk("clr_drained", 64'(sb.size()), 64'd0);
    @(posedge rclk); #1;

    // Reset with two operations in flight
    issue(3'd0, 1'b0, 1'b1, 64'd7, 64'd8, '0);
    ready_mode = 0;
    bus.out_ready = 1'b0;
    issue(3'd1, 1'b0, 1'b1, 64'd9, 64'd2, '0);
    rst = 1'b1;
    sb.delete();
    cyc(1);
    @(negedge rclk);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_cnt", 64'(cnt_ops), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge rclk); #1;
    rst = 1'b0;
    @(negedge rclk);
    chk("midrst_in_ready_after", 64'(bus.in_ready), 64'd1);
    @(posedge rclk); #1;
    ready_mode = 1;
    bus.out_ready = 1'b1;
    cyc(3);
    chk("midrst_no_output", 64'(bus.out_valid), 64'd0);

    // Randomised traffic with random back-pressure and occasional clears
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      cnt_clr = ($urandom_range(0, 15) == 0);
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rnd64(), rnd64(), rnd64());
      if ($urandom_range(0, 3) == 0) cyc(1);
    end
    cnt_clr = 1'b0;
    ready_mode = 1;
    drain();
    cyc(3);
    chk("final_queue_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sparc_exu_alu_pipe.md
# sparc_exu_alu_pipe

Parametrised, pipelined successor to the EXU integer ALU. It accepts one operation per cycle through a valid/ready handshake and computes add/sub/logic/move results over a configurable datapath width. It produces per-32-bit-lane condition codes, a virtual-address range check and a load/store VA. Two register stages (E1 compute, E2 output) absorb downstream stalls without dropping operations, and a saturating completion counter supports bring-up and debug.

## Interface
Parameters:
- WIDTH, 64, datapath width; multiple of 32, minimum 32. LANES = WIDTH/32.
- VA_BITS, 48, implemented virtual-address bits; 2 ≤ VA_BITS ≤ WIDTH.
- CNT_BITS, 32, width of the completion counter.

Ports:
- rclk, in, 1, single clock; all state is updated on its rising edge.
- rst, in, 1, synchronous reset, active high.
- in_valid, in, 1, operation presented.
- in_ready, out, 1, operation accepted this cycle when in_valid && in_ready.
- in_op, in, 3, opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOVE (rs2), 6 PASS (rs3), 7 CASA (ADD result, VA = rs1).
- in_inv, in, 1, invert rs2 before logic ops 2–4 (ANDN/ORN/XNOR); ignored for other ops.
- in_cin, in, 1, carry in for ADD; for SUB it is a borrow, so SUB computes rs1 + ~rs2 + ~in_cin.
- in_rs1 / in_rs2 / in_rs3, in, WIDTH each, operands.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts.
- out_rd, out, WIDTH, result.
- out_va, out, VA_BITS, address for LSU.
- out_n / out_z / out_v / out_c, out, LANES each, per-lane condition codes.
- out_addr_invalid, out, 1, out-of-range VA.
- cnt_clr, in, 1, synchronous clear of the completion counter.
- cnt_ops, out, CNT_BITS, completed-operation count.

## Operation
- **E1 stage**, registered on accept:
  - adder sum is rs1 + (SUB ? ~rs2 : rs2) + carry-in. The carry-in is in_cin for ADD, ~in_cin for SUB, and 0 for CASA.
  - logic result is selected by op.
  - the per-lane carry-out of bit 32k+31 is captured.
  - the operand signs needed for V are captured.
- **E2 stage** registers the result and the condition codes derived from E1.
- **Result selection**:
  - out_rd is the sum for ops 0, 1 and 7.
  - out_rd is the logic result for ops 2–4.
  - out_rd is rs2 for op 5 and rs3 for op 6.
- **Condition codes for lane k** (bits 32k+31:32k):
  - n = bit 32k+31 of out_rd.
  - z = 1 when the lane bits are all zero.
  - c = lane carry-out for ADD/CASA, inverted carry-out (borrow) for SUB, 0 otherwise.
  - v = signed overflow at bit 32k+31 for ADD/SUB/CASA, 0 otherwise.
- **VA**:
  - out_va = rs1[VA_BITS-1:0] for CASA, sum[VA_BITS-1:0] otherwise.
  - out_addr_invalid = 1 when bits [WIDTH-1:VA_BITS-1] of the full-width VA are not all equal. It is evaluated only for ops 0, 1 and 7; otherwise 0. When VA_BITS = WIDTH it is 0.
- **Pipeline control**:
  - e2_adv = ~e2_valid | out_ready.
  - e1_adv = ~e1_valid | e2_adv.
  - in_ready = e1_adv && ~rst (combinational).
  - A stage holds its contents stable while it is not advancing.
- **Counter**:
  - cnt_ops increments on each out_valid && out_ready and saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle, giving a result of 0.

## Timing
- **Reset**: every stage valid bit, out_valid, out_rd, out_va, all condition codes, out_addr_invalid and cnt_ops are 0. in_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- **Latency**: an operation accepted in cycle T appears with out_valid = 1 in cycle T+2 when there is no stall.
- **Throughput**: one operation per cycle with out_ready held high.
- **Output stall**: out_valid stays high and all outputs hold until out_ready is seen. At most 2 operations are buffered; in_ready drops once E2 is full and stalled and E1 is valid.
- **Simultaneous events**:
  - A full pipeline with out_ready high accepts a new input in the same cycle.
  - An accept and a drain in the same cycle keep occupancy constant.
- **Reset mid-operation**: all in-flight operations are discarded in the next cycle; no partial output is produced.
- **Handshake rules**:
  - in_op, the operands and in_cin are sampled only on accept.
  - out_ready may toggle freely.
  - out_valid never falls without a completed handshake, except under reset.

## Test plan
- **ADD carry/overflow** (WIDTH=64): ADD rs1=0x7FFFFFFF_FFFFFFFF, rs2=1, cin=0 → out_rd=0x80000000_00000000 at T+2; n=2'b10, v=2'b10 (lane 1), c=2'b01 (carry out of bit 31), z=2'b01.
- **SUB equal operands**: SUB rs1=rs2=0x1234, cin=0 → out_rd=0, z=2'b11, c=2'b00, v=0.
- **Logic with invert**: AND rs1=0xFF00, rs2=0x0F0F, inv=1 → out_rd=0xF000 (upper bits of rs1 are 0), c=0, v=0.
- **CASA and address check** (VA_BITS=48):
  - CASA rs1=0xFFFF8000_00000000 → out_va=0x8000_00000000 and out_addr_invalid=0.
  - ADD giving 0x00010000_00000000 → out_addr_invalid=1.
  - MOVE of any value → out_addr_invalid=0.
- **Back-pressure**: issue 4 back-to-back ops with out_ready=0 → in_ready drops after 2 accepts, nothing is lost. Raising out_ready drains all 4 in order; cnt_ops=4.
- **Reset and counter edge cases**:
  - Assert rst with 2 ops in flight → out_valid=0 the next cycle and cnt_ops=0.
  - With CNT_BITS=4, run 20 ops → cnt_ops=15 (saturated).
  - cnt_clr together with a completion → cnt_ops=0.
